inst_fifo: RTL and testbench

- Instruction queue between fetch and decode that feeds the dual-issue pair.
- Accepts up to two fetched instructions per cycle and presents the two oldest entries to the master and slave decode slots.
- Retires 0, 1 or 2 entries per cycle as decode issues them.
- Drives the empty and almost-empty status that gates slave issue, and the full status that back-pressures fetch.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/inst_fifo_ptr.sv | 47 ++++
 rtl/inst_fifo.sv | 101 ++++++++++
 tb/tb_inst_fifo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants used by the instruction queue.
package cpu_pkg;

    // One fetched instruction as held in the instruction queue.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        tlb_err;
    } fifo_entry_t;

    localparam int unsigned INST_FIFO_DEPTH = 16;
    localparam int unsigned FIFO_ENTRY_W    = $bits(fifo_entry_t);

endpackage : cpu_pkg

// File: rtl/inst_fifo_ptr.sv
// Head/tail/count bookkeeping for inst_fifo. Increments are 0..2 per cycle;
// reset dominates flush, and flush discards the same-cycle increments.
module inst_fifo_ptr #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [1:0]                 wr_inc,
    input  logic [1:0]                 rd_inc,
    output logic [$clog2(DEPTH)-1:0]   head,
    output logic [$clog2(DEPTH)-1:0]   tail,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next pointer/count state; pointers wrap naturally since DEPTH is 2^n.
    always_comb begin
        head_d  = head_q + PTR_W'(rd_inc);
        tail_d  = tail_q + PTR_W'(wr_inc);
        count_d = count_q + CNT_W'(wr_inc) - CNT_W'(rd_inc);
    end

    // State register: reset first, then flush, then normal update.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head  = head_q;
    assign tail  = tail_q;
    assign count = count_q;

endmodule : inst_fifo_ptr

// File: rtl/inst_fifo.sv
// Dual-issue instruction queue: up to two pushes and two pops per cycle,
// presenting the two oldest entries to the master/slave decode slots.
// Optional macro INST_FIFO_STAT_EN adds saturating issue/empty counters.
module inst_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH   = INST_FIFO_DEPTH,
    parameter int unsigned ENTRY_W = FIFO_ENTRY_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               write_en1,
    input  logic               write_en2,
    input  logic [ENTRY_W-1:0] write_data1,
    input  logic [ENTRY_W-1:0] write_data2,
    input  logic               read_en1,
    input  logic               read_en2,
    output logic [ENTRY_W-1:0] read_data1,
    output logic [ENTRY_W-1:0] read_data2,
    output logic               fifo_empty,
    output logic               fifo_almost_empty,
`ifdef INST_FIFO_STAT_EN
    output logic               fifo_full,
    output logic [31:0]        stat_dual,
    output logic [31:0]        stat_single,
    output logic [31:0]        stat_empty
`else
    output logic               fifo_full
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   head, tail, wr2_addr;
    logic [CNT_W-1:0]   count;
    logic               r1, r2, w1, w2;
    logic [1:0]         wr_inc, rd_inc;

    // Effective reads/writes; writes look only at the registered count.
    always_comb begin
        r1       = read_en1 && (count >= CNT_W'(1));
        r2       = read_en2 && r1 && (count >= CNT_W'(2));
        w1       = write_en1 && !fifo_full;
        w2       = write_en2 && !fifo_full;
        wr_inc   = 2'(w1) + 2'(w2);
        rd_inc   = 2'(r1) + 2'(r2);
        wr2_addr = tail + PTR_W'(w1);
    end

    inst_fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .wr_inc (wr_inc),
        .rd_inc (rd_inc),
        .head   (head),
        .tail   (tail),
        .count  (count)
    );

    // Entry storage; write_data2 is compacted behind write_data1 when both push.
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            if (w1) mem_q[tail]     <= write_data1;
            if (w2) mem_q[wr2_addr] <= write_data2;
        end
    end

    assign read_data1        = mem_q[head];
    assign read_data2        = mem_q[head + PTR_W'(1)];
    assign fifo_empty        = (count == '0);
    assign fifo_almost_empty = (count == CNT_W'(1));
    assign fifo_full         = (count >= CNT_W'(DEPTH - 1));

`ifdef INST_FIFO_STAT_EN
    logic [31:0] stat_dual_q, stat_single_q, stat_empty_q;

    // Saturating statistics; cleared only by reset, flush leaves them alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_dual_q   <= '0;
            stat_single_q <= '0;
            stat_empty_q  <= '0;
        end else begin
            if (r1 && r2 && stat_dual_q != '1)     stat_dual_q   <= stat_dual_q + 32'd1;
            if (r1 && !r2 && stat_single_q != '1)  stat_single_q <= stat_single_q + 32'd1;
            if (fifo_empty && stat_empty_q != '1)  stat_empty_q  <= stat_empty_q + 32'd1;
        end
    end

    assign stat_dual   = stat_dual_q;
    assign stat_single = stat_single_q;
    assign stat_empty  = stat_empty_q;
`endif

endmodule : inst_fifo

// File: tb/tb_inst_fifo.sv
// Directed self-checking bench for inst_fifo (DEPTH=16, ENTRY_W=65).
module tb_inst_fifo;
    import cpu_pkg::*;

    localparam int unsigned W = FIFO_ENTRY_W;

    logic         clk = 1'b0;
    logic         rst_n, flush;
    logic         write_en1, write_en2, read_en1, read_en2;
    logic [W-1:0] write_data1, write_data2;
    logic [W-1:0] read_data1, read_data2;
    logic         fifo_empty, fifo_almost_empty, fifo_full;
`ifdef INST_FIFO_STAT_EN
    logic [31:0]  stat_dual, stat_single, stat_empty;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_fifo #(
        .DEPTH   (16),
        .ENTRY_W (W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .write_en1         (write_en1),
        .write_en2         (write_en2),
        .write_data1       (write_data1),
        .write_data2       (write_data2),
        .read_en1          (read_en1),
        .read_en2          (read_en2),
        .read_data1        (read_data1),
        .read_data2        (read_data2),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
`ifdef INST_FIFO_STAT_EN
        .fifo_full         (fifo_full),
        .stat_dual         (stat_dual),
        .stat_single       (stat_single),
        .stat_empty        (stat_empty)
`else
        .fifo_full         (fifo_full)
`endif
    );

    function automatic logic [W-1:0] ent(input logic [31:0] pc);
        fifo_entry_t e;
        e.pc      = pc;
        e.inst    = ~pc ^ 32'h1357_9BDF;
        e.tlb_err = pc[0];
        return e;
    endfunction

    // Apply one cycle of inputs, then return idle at 1 time unit past the edge.
    task automatic drive(input logic we1, input logic we2,
                         input logic [W-1:0] d1, input logic [W-1:0] d2,
                         input logic re1, input logic re2, input logic fl);
        write_en1 = we1; write_en2 = we2; write_data1 = d1; write_data2 = d2;
        read_en1 = re1; read_en2 = re2; flush = fl;
        @(posedge clk); #1;
        write_en1 = 1'b0; write_en2 = 1'b0; read_en1 = 1'b0; read_en2 = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, ent(32'h900), ent(32'h901), 1'b0, 1'b0, 1'b0);
        do_reset();
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
        checks++; if (fifo_almost_empty !== 1'b0) begin failures++; $display("FAIL reset_aempty got=%b exp=0", fifo_almost_empty); end
        checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
    endtask

    task automatic test_push_pair();
        do_reset();
        drive(1'b1, 1'b1, ent(32'hA), ent(32'hB), 1'b0, 1'b0, 1'b0);
        checks++; if (read_data1 !== ent(32'hA)) begin failures++; $display("FAIL pair_rd1 got=%h exp=%h", read_data1, ent(32'hA)); end
        checks++; if (read_data2 !== ent(32'hB)) begin failures++; $display("FAIL pair_rd2 got=%h exp=%h", read_data2, ent(32'hB)); end
        checks++; if (fifo_empty !== 1'b0 || fifo_almost_empty !== 1'b0)
            begin failures++; $display("FAIL pair_status got=%b%b exp=00", fifo_empty, fifo_almost_empty); end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL pair_pop2 got=%b exp=1", fifo_empty); end
    endtask

    task automatic test_read_gating();
        do_reset();
        drive(1'b1, 1'b0, ent(32'h10), '0, 1'b0, 1'b0, 1'b0);
        // read_en2 alone must be ignored
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checks++; if (fifo_almost_empty !== 1'b1 || read_data1 !== ent(32'h10))
            begin failures++; $display("FAIL re2_alone got=%b/%h exp=1/%h", fifo_almost_empty, read_data1, ent(32'h10)); end
        // count=1 with both reads: only one entry popped
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        checks++; if (fifo_empty !== 1'b1 || fifo_almost_empty !== 1'b0)
            begin failures++; $display("FAIL pop_at_one got=%b%b exp=10", fifo_empty, fifo_almost_empty); end
        // read and write together at count 1
        drive(1'b1, 1'b0, ent(32'h20), '0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, ent(32'h21), '0, 1'b1, 1'b0, 1'b0);
        checks++; if (read_data1 !== ent(32'h21) || fifo_almost_empty !== 1'b1)
            begin failures++; $display("FAIL rw_at_one got=%h/%b exp=%h/1", read_data1, fifo_almost_empty, ent(32'h21)); end
        // read and write together at count 0: write lands, nothing popped
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, ent(32'h22), '0, 1'b1, 1'b1, 1'b0);
        checks++; if (read_data1 !== ent(32'h22) || fifo_almost_empty !== 1'b1)
            begin failures++; $display("FAIL rw_at_zero got=%h/%b exp=%h/1", read_data1, fifo_almost_empty, ent(32'h22)); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 7; i++)
            drive(1'b1, 1'b1, ent(32'(2*i)), ent(32'(2*i+1)), 1'b0, 1'b0, 1'b0);
        checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL full_at14 got=%b exp=0", fifo_full); end
        drive(1'b1, 1'b0, ent(32'd14), '0, 1'b0, 1'b0, 1'b0);
        checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL full_at15 got=%b exp=1", fifo_full); end
        drive(1'b1, 1'b1, ent(32'h100), ent(32'h101), 1'b1, 1'b0, 1'b0);
        checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL full_drop got=%b exp=0", fifo_full); end
        for (int k = 0; k < 7; k++) begin
            checks++; if (read_data1 !== ent(32'(1+2*k)) || read_data2 !== ent(32'(2+2*k)))
                begin failures++; $display("FAIL full_drain%0d got=%h,%h exp=%h,%h", k, read_data1, read_data2, ent(32'(1+2*k)), ent(32'(2+2*k))); end
            drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        end
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL full_drained got=%b exp=1", fifo_empty); end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 1'b1, ent(32'h1000), ent(32'h1001), 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 40; n++) begin
            checks++; if (read_data1 !== ent(32'(32'h1000 + 2*n)) || read_data2 !== ent(32'(32'h1001 + 2*n)))
                begin failures++; $display("FAIL wrap%0d got=%h,%h exp=%h,%h", n, read_data1, read_data2, ent(32'(32'h1000 + 2*n)), ent(32'(32'h1001 + 2*n))); end
            drive(1'b1, 1'b1, ent(32'(32'h1002 + 2*n)), ent(32'(32'h1003 + 2*n)), 1'b1, 1'b1, 1'b0);
        end
        checks++; if (read_data1 !== ent(32'h1050) || read_data2 !== ent(32'h1051) || fifo_empty !== 1'b0 || fifo_almost_empty !== 1'b0)
            begin failures++; $display("FAIL wrap_tail got=%h,%h exp=%h,%h", read_data1, read_data2, ent(32'h1050), ent(32'h1051)); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 1'b1, ent(32'h50), ent(32'h51), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, ent(32'h52), ent(32'h53), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, ent(32'h54), '0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, ent(32'h66), '0, 1'b1, 1'b0, 1'b1);
        checks++; if (fifo_empty !== 1'b1 || fifo_almost_empty !== 1'b0)
            begin failures++; $display("FAIL flush_empty got=%b%b exp=10", fifo_empty, fifo_almost_empty); end
        drive(1'b1, 1'b0, ent(32'h77), '0, 1'b0, 1'b0, 1'b0);
        checks++; if (read_data1 !== ent(32'h77) || fifo_almost_empty !== 1'b1)
            begin failures++; $display("FAIL flush_after got=%h/%b exp=%h/1", read_data1, fifo_almost_empty, ent(32'h77)); end
    endtask

    task automatic test_write2_only();
        do_reset();
        drive(1'b0, 1'b1, '0, ent(32'hC), 1'b0, 1'b0, 1'b0);
        checks++; if (read_data1 !== ent(32'hC)) begin failures++; $display("FAIL w2only_rd1 got=%h exp=%h", read_data1, ent(32'hC)); end
        checks++; if (fifo_almost_empty !== 1'b1 || fifo_empty !== 1'b0)
            begin failures++; $display("FAIL w2only_status got=%b%b exp=01", fifo_empty, fifo_almost_empty); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++)
            drive(1'b1, 1'b1, ent(32'(i)), ent(32'(i + 100)), 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        drive(1'b1, 1'b1, ent(32'h3), ent(32'h4), 1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        checks++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0)
            begin failures++; $display("FAIL reset_mid got=%b%b exp=10", fifo_empty, fifo_full); end
    endtask

    initial begin
        rst_n = 1'b1; flush = 1'b0;
        write_en1 = 1'b0; write_en2 = 1'b0; read_en1 = 1'b0; read_en2 = 1'b0;
        write_data1 = '0; write_data2 = '0;
        test_reset();
        test_push_pair();
        test_read_gating();
        test_full();
        test_wrap();
        test_flush();
        test_write2_only();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_inst_fifo
